i2c_cmd_arbiter: RTL and testbench
==================================

// Module: i2c_cmd_arbiter
// PURPOSE
//  Shares one I2C_Controller between N_REQ configuration masters (audio codec, video decoder, camera setup).
//  Each master presents a 24-bit word {SLAVE_ADDR,SUB_ADDR,DATA}; the block grants the bus round-robin.
//  It drives the controller GO/DATA pair and detects END/ACK. It retries on NACK and times out on a hung transfer.
//  Sits between the per-master config sequencers and the single I2C_Controller instance.
// PARAMETERS
//  N_REQ        4        number of requesters (2..8)
//  MAX_RETRY    3        extra attempts after a NACK before flagging error
//  TIMEOUT_CYC  2000000  iCLK cycles allowed from GO high to END rising edge
//  GAP_CYC      1000     iCLK cycles GO held low between attempts/transfers
// PORTS
//  iCLK        in   1         system clock (50 MHz)
//  iRST_N      in   1         reset, synchronous, active-low
//  iREQ        in   N_REQ     per-master request level, held until oDONE/oERR pulse
//  iREQ_DATA   in   N_REQ*24  per-master word; master k uses bits [24k+23:24k]
//  oGNT        out  N_REQ     one-hot grant, high for the whole transaction
//  oDONE       out  N_REQ     1-cycle pulse: transfer acknowledged
//  oERR        out  N_REQ     1-cycle pulse: retries exhausted or timeout
//  oI2C_DATA   out  24        word to the controller, stable while oI2C_GO=1
//  oI2C_GO     out  1         start request to the controller
//  iI2C_END    in   1         controller end flag (slow-clock domain)
//  iI2C_ACK    in   1         controller ack flag; 1 = NACK seen (slow-clock domain)
//  oBUSY       out  1         high in any state other than IDLE
// BEHAVIOUR
//  Reset (iRST_N=0 at iCLK edge): state=IDLE; oGNT,oDONE,oERR=0; oI2C_GO=0; oI2C_DATA=0; oBUSY=0.
//   Round-robin pointer=0; retry and timer counters=0. Reset mid-transfer drops GO the next cycle.
//  iI2C_END and iI2C_ACK pass through 2-flop synchronizers. END rise = sync END 1 now and 0 in the previous cycle.
//  FSM:
//   IDLE  : if any iREQ, pick the first set bit at or after ptr, wrapping from N_REQ-1 to 0.
//           Latch its data into oI2C_DATA, set oGNT one-hot, clear retry count -> ISSUE. Next cycle oBUSY=1.
//   ISSUE : oI2C_GO=1, timer=0 -> XFER
//   XFER  : timer++. On END rise: if sync ACK=0 -> DONE.
//           If sync ACK=1 and retry<MAX_RETRY: retry++ -> GAP. Otherwise -> FAIL.
//           If timer reaches TIMEOUT_CYC-1 with no END rise -> FAIL.
//           If END rise and timeout land in the same cycle, END wins.
//   GAP   : oI2C_GO=0, count GAP_CYC cycles -> ISSUE. Same master; oI2C_DATA is not re-latched.
//   DONE  : oDONE[g]=1 for one cycle, GO=0, ptr=g+1 mod N_REQ -> REST
//   FAIL  : oERR[g]=1 for one cycle, GO=0, ptr=g+1 mod N_REQ -> REST
//   REST  : GO=0 for GAP_CYC cycles so the controller re-arms; oGNT cleared on entry -> IDLE
//  oGNT is high from the cycle after IDLE decides until REST entry.
//  A master that drops iREQ while granted does not abort the transfer; it still gets oDONE/oERR.
//  Requests arriving mid-transaction wait; there is no preemption.
//  Fairness: with all N_REQ requesting, each master is served once per N_REQ transactions.
//  Counters: timer is ceil(log2(TIMEOUT_CYC)) bits, saturating. Retry is ceil(log2(MAX_RETRY+1)) bits.
//  MAX_RETRY=0 means the first NACK goes straight to FAIL.
// STRUCTURE
//  Shared package i2c_cfg_pkg: I2C_WORD_W=24, the state enum (IDLE..REST), the ACK_NACK=1 encoding.
//  Sub-module rr_pick (combinational round-robin selector: req,ptr -> one-hot, valid). Used only in IDLE.
//  Synchronizers are inline. No other sub-modules.
// TESTING
//  Use a behavioural controller model: END rises 40 cycles after GO, ACK set by the bench. Overrides: TIMEOUT_CYC=200, GAP_CYC=8.
//  1 Single master: iREQ=4'b0010, data 24'h34_0E_80, ACK=0
//    -> oI2C_DATA=24'h340E80, one oDONE[1] pulse, ptr=2, oBUSY low after REST.
//  2 All four request together from reset
//    -> grants in order 0,1,2,3, each with exactly one oDONE; no overlapping oGNT bits.
//  3 NACK on the first two attempts, then ACK, MAX_RETRY=3
//    -> three GO pulses separated by 8-cycle gaps, then oDONE; no oERR.
//  4 Persistent NACK, MAX_RETRY=3
//    -> four GO pulses, then oERR for the granted master; the next master is served afterwards.
//  5 Controller never raises END
//    -> oERR exactly 200 cycles after GO rises; GO low the following cycle.
//  6 iRST_N low for 1 cycle mid-XFER
//    -> next cycle all outputs 0 and state IDLE; the pending iREQ is re-arbitrated from master 0.

Source files
------------

// File: rtl/i2c_cfg_pkg.sv
`default_nettype none
// i2c_cfg_pkg: word width, arbiter FSM states and controller ACK encoding.
// Revision: 1.0
package i2c_cfg_pkg;

   localparam int I2C_WORD_W = 24;

   // I2C_Controller reports a NACK by raising its ACK flag
   localparam logic ACK_NACK = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_XFER  = 3'd2,
      ST_GAP   = 3'd3,
      ST_DONE  = 3'd4,
      ST_FAIL  = 3'd5,
      ST_REST  = 3'd6
   } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// rr_pick: combinational round-robin selector, first request at or after ptr with wrap.
// Revision: 1.0
module rr_pick #(
   parameter int N_REQ = 4,
   parameter int PTR_W = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] gnt,
   output logic             valid
);

   always_comb begin
      gnt   = '0;
      valid = 1'b0;
      // Upper segment [ptr..N_REQ-1] takes priority over the wrapped segment [0..ptr-1]
      for (int k = 0; k < N_REQ; k++) begin
         if (!valid && req[k] && (k >= int'(ptr))) begin
            gnt[k] = 1'b1;
            valid  = 1'b1;
         end
      end
      for (int k = 0; k < N_REQ; k++) begin
         if (!valid && req[k] && (k < int'(ptr))) begin
            gnt[k] = 1'b1;
            valid  = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/i2c_cmd_arbiter.sv
`default_nettype none
// i2c_cmd_arbiter: round-robin sharing of one I2C_Controller with NACK retry and hang timeout.
// Revision: 1.0
module i2c_cmd_arbiter
   import i2c_cfg_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int MAX_RETRY   = 3,
   parameter int TIMEOUT_CYC = 2000000,
   parameter int GAP_CYC     = 1000
) (
   input  logic                        iCLK,
   input  logic                        iRST_N,
   input  logic [N_REQ-1:0]            iREQ,
   input  logic [N_REQ*I2C_WORD_W-1:0] iREQ_DATA,
   output logic [N_REQ-1:0]            oGNT,
   output logic [N_REQ-1:0]            oDONE,
   output logic [N_REQ-1:0]            oERR,
   output logic [I2C_WORD_W-1:0]       oI2C_DATA,
   output logic                        oI2C_GO,
   input  logic                        iI2C_END,
   input  logic                        iI2C_ACK,
   output logic                        oBUSY
);

   localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int TIMER_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
   localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
   localparam logic [GAP_W-1:0]   GAP_LAST   = GAP_W'(GAP_CYC - 1);
   localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(N_REQ - 1);

   arb_state_t              state;
   arb_state_t              state_nxt;
   logic [PTR_W-1:0]        ptr;
   logic [PTR_W-1:0]        gnt_idx;
   logic [N_REQ-1:0]        gnt;
   logic [I2C_WORD_W-1:0]   data;
   logic [RETRY_W-1:0]      retry;
   logic [TIMER_W-1:0]      timer;
   logic [GAP_W-1:0]        gap_cnt;
   logic [2:0]              end_sync;
   logic [1:0]              ack_sync;
   logic                    end_rise;
   logic                    ack_nack;
   logic [N_REQ-1:0]        pick_gnt;
   logic                    pick_valid;
   logic [I2C_WORD_W-1:0]   pick_data;

   rr_pick #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_pick (
      .req   (iREQ),
      .ptr   (ptr),
      .gnt   (pick_gnt),
      .valid (pick_valid)
   );

   // Synchronizers are left out of reset so an END still high after an abort cannot fake a rise
   always_ff @(posedge iCLK) begin
      end_sync <= {end_sync[1:0], iI2C_END};
      ack_sync <= {ack_sync[0], iI2C_ACK};
   end

   assign end_rise = end_sync[1] & ~end_sync[2];
   assign ack_nack = (ack_sync[1] == ACK_NACK);

   always_comb begin
      pick_data = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (pick_gnt[k]) begin
            pick_data = pick_data | iREQ_DATA[k*I2C_WORD_W +: I2C_WORD_W];
         end
      end
   end

   always_comb begin
      gnt_idx = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (gnt[k]) begin
            gnt_idx = PTR_W'(k);
         end
      end
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      oI2C_GO   = 1'b0;
      oDONE     = '0;
      oERR      = '0;
      oBUSY     = (state != ST_IDLE);
      case (state)
         ST_IDLE: begin
            if (pick_valid) state_nxt = ST_ISSUE;
         end
         ST_ISSUE: begin
            oI2C_GO   = 1'b1;
            state_nxt = ST_XFER;
         end
         ST_XFER: begin
            oI2C_GO = 1'b1;
            // END rise is tested first so it wins a tie with the timeout
            if (end_rise) begin
               if (!ack_nack)              state_nxt = ST_DONE;
               else if (retry < RETRY_MAX) state_nxt = ST_GAP;
               else                        state_nxt = ST_FAIL;
            end else if (timer == TIMER_LAST) begin
               state_nxt = ST_FAIL;
            end
         end
         ST_GAP: begin
            if (gap_cnt == GAP_LAST) state_nxt = ST_ISSUE;
         end
         ST_DONE: begin
            oDONE     = gnt;
            state_nxt = ST_REST;
         end
         ST_FAIL: begin
            oERR      = gnt;
            state_nxt = ST_REST;
         end
         ST_REST: begin
            if (gap_cnt == GAP_LAST) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         ptr     <= '0;
         gnt     <= '0;
         data    <= '0;
         retry   <= '0;
         timer   <= '0;
         gap_cnt <= '0;
      end else begin
         // Timer reads 0 in the ISSUE cycle, so its value is cycles since GO rose
         if (state == ST_ISSUE || state == ST_XFER) begin
            if (timer != '1) timer <= timer + 1'b1;
         end else begin
            timer <= '0;
         end

         if ((state == ST_GAP || state == ST_REST) && (gap_cnt != GAP_LAST)) begin
            gap_cnt <= gap_cnt + 1'b1;
         end else begin
            gap_cnt <= '0;
         end

         case (state)
            ST_IDLE: begin
               if (pick_valid) begin
                  gnt   <= pick_gnt;
                  data  <= pick_data;
                  retry <= '0;
               end
            end
            ST_XFER: begin
               if (end_rise && ack_nack && (retry < RETRY_MAX)) begin
                  retry <= retry + 1'b1;
               end
            end
            ST_DONE, ST_FAIL: begin
               gnt <= '0;
               ptr <= (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign oGNT      = gnt;
   assign oI2C_DATA = data;

endmodule
`default_nettype wire

// File: tb/tb_i2c_cmd_arbiter.sv
`default_nettype none
// tb_i2c_cmd_arbiter: scoreboard bench with a behavioural I2C controller and arbitration model.
// Revision: 1.0
module tb_i2c_cmd_arbiter;

   localparam int N       = 4;
   localparam int MR      = 3;
   localparam int TO      = 200;
   localparam int GAP     = 8;
   localparam int END_DLY = 40;

   typedef struct {
      int          m;
      logic [23:0] data;
      bit          is_err;
      int          n_go;
      bit          hang;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req;
   logic [N*24-1:0] req_data;
   logic [N-1:0]  gnt, done, err;
   logic [23:0]   i2c_data;
   logic          go, i2c_end, i2c_ack, busy;

   int   n_chk  = 0;
   int   n_fail = 0;
   int   mptr;
   int   nack_plan [N];
   bit   hang_plan [N];
   exp_t sb [$];

   always #5 clk = ~clk;

   i2c_cmd_arbiter #(
      .N_REQ       (N),
      .MAX_RETRY   (MR),
      .TIMEOUT_CYC (TO),
      .GAP_CYC     (GAP)
   ) dut (
      .iCLK      (clk),
      .iRST_N    (rst_n),
      .iREQ      (req),
      .iREQ_DATA (req_data),
      .oGNT      (gnt),
      .oDONE     (done),
      .oERR      (err),
      .oI2C_DATA (i2c_data),
      .oI2C_GO   (go),
      .iI2C_END  (i2c_end),
      .iI2C_ACK  (i2c_ack),
      .oBUSY     (busy)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic flag(input string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s: expected event did not occur within its bound", nm);
   endtask

   function automatic int idx_of(input logic [N-1:0] g);
      int r;
      r = 0;
      for (int i = N - 1; i >= 0; i--) if (g[i]) r = i;
      return r;
   endfunction

   // Reference model: serve pending masters in wrap order from the model pointer
   task automatic start_batch(input logic [N-1:0] mask);
      logic [N-1:0] rem;
      exp_t e;
      rem = mask;
      while (rem != '0) begin
         for (int i = 0; i < N; i++) begin
            int k;
            k = (mptr + i) % N;
            if (rem[k]) begin
               e.m    = k;
               e.data = req_data[k*24 +: 24];
               e.hang = hang_plan[k];
               if (hang_plan[k]) begin
                  e.is_err = 1'b1; e.n_go = 1;
               end else if (nack_plan[k] <= MR) begin
                  e.is_err = 1'b0; e.n_go = nack_plan[k] + 1;
               end else begin
                  e.is_err = 1'b1; e.n_go = MR + 1;
               end
               sb.push_back(e);
               rem[k] = 1'b0;
               mptr   = (k + 1) % N;
               break;
            end
         end
      end
      req = req | mask;
   endtask

   task automatic wait_batch();
      int t;
      t = 0;
      while (req != '0 && t < 20000) begin
         @(negedge clk);
         t++;
         for (int k = 0; k < N; k++) if (done[k] || err[k]) req[k] = 1'b0;
      end
      if (req != '0) begin
         flag("batch_complete");
         req = '0;
      end
      t = 0;
      while (busy && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (busy) flag("return_idle");
   endtask

   // Controller model: END rises END_DLY cycles after GO, drops with GO
   initial begin : ctrl_model
      int age, attempts, cur;
      logic [N-1:0] last_gnt;
      i2c_end = 1'b0; i2c_ack = 1'b0;
      age = 0; attempts = 0; last_gnt = '0;
      forever begin
         @(negedge clk);
         if (gnt != last_gnt) attempts = 0;
         last_gnt = gnt;
         cur = idx_of(gnt);
         if (!go) begin
            age = 0;
            i2c_end = 1'b0;
         end else begin
            age++;
            if (age == END_DLY && !hang_plan[cur]) begin
               i2c_ack = (attempts < nack_plan[cur]);
               i2c_end = 1'b1;
               attempts++;
            end
         end
      end
   end

   initial begin : monitor
      exp_t e;
      int   cyc, n_go, last_rise, last_fall;
      bit   go_prev, go_low_pending;
      cyc = 0; n_go = 0; last_rise = 0; last_fall = 0;
      go_prev = 1'b0; go_low_pending = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         if (!rst_n) begin
            n_go = 0; go_prev = 1'b0; go_low_pending = 1'b0;
         end else begin
            if (go_low_pending) begin
               check("go_low_after_end", go, 0);
               go_low_pending = 1'b0;
            end
            check("gnt_onehot", $onehot0(gnt), 1);
            if (go && !go_prev) begin
               n_go++;
               if (n_go > 1) check("retry_gap", cyc - last_fall, GAP);
               last_rise = cyc;
               if (sb.size() > 0) begin
                  check("go_gnt", gnt, 32'(1) << sb[0].m);
                  check("go_data", i2c_data, sb[0].data);
               end else begin
                  flag("go_expected_txn");
               end
            end
            if (!go && go_prev) last_fall = cyc;
            if ((done != '0) || (err != '0)) begin
               if (sb.size() == 0) begin
                  flag("completion_expected_txn");
               end else begin
                  e = sb.pop_front();
                  check("cmpl_master", done | err, 32'(1) << e.m);
                  check("cmpl_is_err", (err != '0), e.is_err);
                  check("go_count", n_go, e.n_go);
                  if (e.hang) check("timeout_latency", cyc - last_rise, TO);
                  go_low_pending = 1'b1;
               end
               n_go = 0;
            end
            go_prev = go;
         end
      end
   end

   initial begin : main
      int t;
      logic [N-1:0] mask;
      rst_n = 1'b0; req = '0; req_data = '0; mptr = 0;
      for (int k = 0; k < N; k++) begin
         nack_plan[k] = 0;
         hang_plan[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
      check("rst_gnt", gnt, 0);
      check("rst_done_err", done | err, 0);
      check("rst_go", go, 0);
      check("rst_data", i2c_data, 0);
      check("rst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // Single master, then time the drop of busy after its done pulse
      req_data[1*24 +: 24] = 24'h340E80;
      start_batch(4'b0010);
      t = 0;
      while (!done[1] && t < 2000) begin
         @(negedge clk);
         t++;
      end
      if (!done[1]) flag("single_done");
      req[1] = 1'b0;
      t = 0;
      do begin
         @(posedge clk);
         #1;
         t++;
      end while (busy && t < 50);
      check("busy_drop_latency", t, GAP + 1);

      // Reset mid-transfer: pointer sits at 2, so master 3 is served before the reset
      req_data[1*24 +: 24] = 24'(32'($urandom));
      req_data[3*24 +: 24] = 24'(32'($urandom));
      start_batch(4'b1010);
      t = 0;
      while (!go && t < 500) begin
         @(negedge clk);
         t++;
      end
      if (!go) flag("go_before_reset");
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      sb.delete();
      mptr = 0;
      @(posedge clk);
      #1;
      check("midrst_gnt", gnt, 0);
      check("midrst_done_err", done | err, 0);
      check("midrst_go", go, 0);
      check("midrst_data", i2c_data, 0);
      check("midrst_busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      start_batch(4'b1010);
      wait_batch();

      // All four at once
      for (int k = 0; k < N; k++) req_data[k*24 +: 24] = 24'(32'($urandom));
      start_batch(4'b1111);
      wait_batch();

      // Two NACKs then ACK
      nack_plan[0] = 2;
      start_batch(4'b0001);
      wait_batch();
      nack_plan[0] = 0;

      // Persistent NACK, next master served afterwards
      nack_plan[1] = 9;
      start_batch(4'b0110);
      wait_batch();
      nack_plan[1] = 0;

      // Controller hangs
      hang_plan[3] = 1'b1;
      start_batch(4'b1000);
      wait_batch();
      hang_plan[3] = 1'b0;

      repeat (12) begin
         mask = 4'($urandom_range(1, 15));
         for (int k = 0; k < N; k++) begin
            req_data[k*24 +: 24] = 24'(32'($urandom));
            nack_plan[k] = $urandom_range(0, 5);
            hang_plan[k] = ($urandom_range(0, 7) == 0);
         end
         start_batch(mask);
         wait_batch();
      end

      repeat (20) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
